// File: rtl/multi_sel_rx.sv
// multi_sel_rx: frame aligner and checker for the x1/x3/x7/x8 product stream.
// It locks onto the grant strobe and rebuilds each product from the captured
// operand using shifts and adds. Once per frame it reports either the verified
// operand or an error code. Saturating good and bad counters are kept for debug.
module multi_sel_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        grant_in,
  input  logic [10:0] din,
  output logic [7:0]  op_out,
  output logic        op_valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        locked,
  output logic [7:0]  good_cnt,
  output logic [7:0]  bad_cnt
);

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    P0   = 3'd4
  } state_t;

  localparam logic [1:0] CODE_MISMATCH = 2'd1;
  localparam logic [1:0] CODE_SHORT    = 2'd2;
  localparam logic [1:0] CODE_LOST     = 2'd3;

  state_t      state;
  logic [7:0]  x;
  logic        bad;

  logic [10:0] x_ext;
  logic [10:0] x3;
  logic [10:0] x7;
  logic [10:0] x8;
  logic        range_bad;

  // Counter increment that holds at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Expected products, rebuilt from the captured operand with shifts and adds.
  always_comb begin
    x_ext     = {3'b000, x};
    x3        = (x_ext << 1) + x_ext;
    x7        = (x_ext << 3) - x_ext;
    x8        = x_ext << 3;
    range_bad = (din[10:8] != 3'b000);
  end

  // Frame FSM with registered status pulses, operand and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HUNT;
      x        <= 8'd0;
      bad      <= 1'b0;
      op_out   <= 8'd0;
      op_valid <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      locked   <= 1'b0;
      good_cnt <= 8'd0;
      bad_cnt  <= 8'd0;
    end else begin
      op_valid <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      case (state)
        HUNT: begin
          if (grant_in) begin
            x      <= din[7:0];
            bad    <= range_bad;
            locked <= 1'b1;
            state  <= P1;
          end
        end
        P1, P2, P3: begin
          if (grant_in) begin
            // A strobe arriving early ends the current frame. The same word
            // is then taken as the x1 word of the next frame.
            err      <= 1'b1;
            err_code <= CODE_SHORT;
            bad_cnt  <= sat_inc(bad_cnt);
            x        <= din[7:0];
            bad      <= range_bad;
            state    <= P1;
          end else if (state == P1) begin
            if (din != x3) bad <= 1'b1;
            state <= P2;
          end else if (state == P2) begin
            if (din != x7) bad <= 1'b1;
            state <= P3;
          end else begin
            if (bad || (din != x8)) begin
              err      <= 1'b1;
              err_code <= CODE_MISMATCH;
              bad_cnt  <= sat_inc(bad_cnt);
            end else begin
              op_out   <= x;
              op_valid <= 1'b1;
              good_cnt <= sat_inc(good_cnt);
            end
            state <= P0;
          end
        end
        P0: begin
          if (grant_in) begin
            x     <= din[7:0];
            bad   <= range_bad;
            state <= P1;
          end else begin
            err      <= 1'b1;
            err_code <= CODE_LOST;
            bad_cnt  <= sat_inc(bad_cnt);
            locked   <= 1'b0;
            state    <= HUNT;
          end
        end
        default: begin
          locked <= 1'b0;
          state  <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_sel_rx.sv
// Testbench for multi_sel_rx. It applies a table of directed vectors and then
// runs the saturation and mid-frame reset sequences. Last comes a randomized
// stream checked against a frame-level reference model.
module tb_multi_sel_rx;

  logic        clk;
  logic        rst;
  logic        grant_in;
  logic [10:0] din;
  logic [7:0]  op_out;
  logic        op_valid;
  logic        err;
  logic [1:0]  err_code;
  logic        locked;
  logic [7:0]  good_cnt;
  logic [7:0]  bad_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  multi_sel_rx dut (
    .clk      (clk),
    .rst      (rst),
    .grant_in (grant_in),
    .din      (din),
    .op_out   (op_out),
    .op_valid (op_valid),
    .err      (err),
    .err_code (err_code),
    .locked   (locked),
    .good_cnt (good_cnt),
    .bad_cnt  (bad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {op_valid, err, err_code, locked, op_out, good_cnt, bad_cnt}
  function automatic logic [28:0] pk(input logic ov, input logic e, input logic [1:0] c,
                                     input logic l, input logic [7:0] op,
                                     input logic [7:0] gc, input logic [7:0] bc);
    pk = {ov, e, c, l, op, gc, bc};
  endfunction

  function automatic logic [28:0] outs();
    outs = {op_valid, err, err_code, locked, op_out, good_cnt, bad_cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one word at the falling edge, then return 1 ns after the next rising edge.
  task automatic step(input logic g, input logic [10:0] d);
    @(negedge clk);
    grant_in = g;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    grant_in = 1'b0;
    din = 11'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model: collect the words of the current frame and judge the
  // frame as a whole, using multiplication rather than shifts.
  int   mq[$];
  bit   m_sync;
  logic m_ov, m_err, m_lock;
  logic [1:0] m_code;
  logic [7:0] m_op, m_good, m_bad;

  task automatic model_reset();
    mq.delete();
    m_sync = 0;
    m_ov = 0; m_err = 0; m_code = 0; m_lock = 0;
    m_op = 0; m_good = 0; m_bad = 0;
  endtask

  task automatic model_step(input logic g, input logic [10:0] d);
    int xv;
    m_ov = 0; m_err = 0; m_code = 0;
    if (!m_sync) begin
      if (g) begin
        mq.delete(); mq.push_back(int'(d)); m_sync = 1;
      end
    end else if (g) begin
      if (mq.size() < 4) begin
        m_err = 1; m_code = 2;
        if (m_bad != 255) m_bad++;
      end
      mq.delete(); mq.push_back(int'(d));
    end else begin
      mq.push_back(int'(d));
      if (mq.size() == 4) begin
        xv = mq[0] % 256;
        if (mq[0] < 256 && mq[1] == 3 * xv && mq[2] == 7 * xv && mq[3] == 8 * xv) begin
          m_ov = 1; m_op = 8'(xv);
          if (m_good != 255) m_good++;
        end else begin
          m_err = 1; m_code = 1;
          if (m_bad != 255) m_bad++;
        end
      end else if (mq.size() == 5) begin
        m_err = 1; m_code = 3;
        if (m_bad != 255) m_bad++;
        m_sync = 0;
        mq.delete();
      end
    end
    m_lock = m_sync;
  endtask

  typedef struct {
    logic        g;
    logic [10:0] d;
    logic [28:0] exp;
  } vec_t;

  vec_t tbl[30];

  typedef struct {
    logic        g;
    logic [10:0] d;
  } word_t;

  word_t plan[$];

  task automatic plan_frame();
    int op, kind, len, gap;
    word_t w;
    logic [10:0] f[4];
    op = int'($urandom_range(0, 255));
    f[0] = 11'(op); f[1] = 11'(3 * op); f[2] = 11'(7 * op); f[3] = 11'(8 * op);
    kind = int'($urandom_range(0, 99));
    len = 4;
    gap = 0;
    if (kind < 10)      f[$urandom_range(1, 3)] ^= 11'(1 << $urandom_range(0, 10));
    else if (kind < 15) f[0][10:8] = 3'($urandom_range(1, 7));
    else if (kind < 23) len = int'($urandom_range(1, 3));
    else if (kind < 30) gap = int'($urandom_range(1, 3));
    for (int i = 0; i < len; i++) begin
      w.g = (i == 0); w.d = f[i]; plan.push_back(w);
    end
    for (int i = 0; i < gap; i++) begin
      w.g = 1'b0; w.d = 11'($urandom_range(0, 2047)); plan.push_back(w);
    end
  endtask

  initial begin
    int ov_cnt;
    word_t w;
    rst = 1'b1;
    grant_in = 1'b0;
    din = 11'd0;

    // Directed vectors: good frames, mismatch, range error, short and lost frames.
    tbl[0]  = '{1, 11'd5,    pk(0,0,0,1,8'd0,  8'd0,8'd0)};
    tbl[1]  = '{0, 11'd15,   pk(0,0,0,1,8'd0,  8'd0,8'd0)};
    tbl[2]  = '{0, 11'd35,   pk(0,0,0,1,8'd0,  8'd0,8'd0)};
    tbl[3]  = '{0, 11'd40,   pk(1,0,0,1,8'd5,  8'd1,8'd0)};
    tbl[4]  = '{1, 11'd255,  pk(0,0,0,1,8'd5,  8'd1,8'd0)};
    tbl[5]  = '{0, 11'd765,  pk(0,0,0,1,8'd5,  8'd1,8'd0)};
    tbl[6]  = '{0, 11'd1785, pk(0,0,0,1,8'd5,  8'd1,8'd0)};
    tbl[7]  = '{0, 11'd2040, pk(1,0,0,1,8'd255,8'd2,8'd0)};
    tbl[8]  = '{1, 11'd5,    pk(0,0,0,1,8'd255,8'd2,8'd0)};
    tbl[9]  = '{0, 11'd15,   pk(0,0,0,1,8'd255,8'd2,8'd0)};
    tbl[10] = '{0, 11'd36,   pk(0,0,0,1,8'd255,8'd2,8'd0)};
    tbl[11] = '{0, 11'd40,   pk(0,1,1,1,8'd255,8'd2,8'd1)};
    tbl[12] = '{1, 11'h105,  pk(0,0,0,1,8'd255,8'd2,8'd1)};
    tbl[13] = '{0, 11'd15,   pk(0,0,0,1,8'd255,8'd2,8'd1)};
    tbl[14] = '{0, 11'd35,   pk(0,0,0,1,8'd255,8'd2,8'd1)};
    tbl[15] = '{0, 11'd40,   pk(0,1,1,1,8'd255,8'd2,8'd2)};
    tbl[16] = '{1, 11'd5,    pk(0,0,0,1,8'd255,8'd2,8'd2)};
    tbl[17] = '{0, 11'd15,   pk(0,0,0,1,8'd255,8'd2,8'd2)};
    tbl[18] = '{1, 11'd9,    pk(0,1,2,1,8'd255,8'd2,8'd3)};
    tbl[19] = '{0, 11'd27,   pk(0,0,0,1,8'd255,8'd2,8'd3)};
    tbl[20] = '{0, 11'd63,   pk(0,0,0,1,8'd255,8'd2,8'd3)};
    tbl[21] = '{0, 11'd72,   pk(1,0,0,1,8'd9,  8'd3,8'd3)};
    tbl[22] = '{0, 11'd0,    pk(0,1,3,0,8'd9,  8'd3,8'd4)};
    tbl[23] = '{0, 11'd5,    pk(0,0,0,0,8'd9,  8'd3,8'd4)};
    tbl[24] = '{0, 11'd0,    pk(0,0,0,0,8'd9,  8'd3,8'd4)};
    tbl[25] = '{1, 11'd3,    pk(0,0,0,1,8'd9,  8'd3,8'd4)};
    tbl[26] = '{0, 11'd9,    pk(0,0,0,1,8'd9,  8'd3,8'd4)};
    tbl[27] = '{0, 11'd21,   pk(0,0,0,1,8'd9,  8'd3,8'd4)};
    tbl[28] = '{0, 11'd24,   pk(1,0,0,1,8'd3,  8'd4,8'd4)};
    tbl[29] = '{0, 11'd0,    pk(0,1,3,0,8'd3,  8'd4,8'd5)};

    do_reset();
    #1;
    chk("reset_state", 32'(outs()), 32'(pk(0,0,0,0,0,0,0)));
    for (int i = 0; i < 30; i++) begin
      step(tbl[i].g, tbl[i].d);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // Saturation: 300 back-to-back good frames.
    do_reset();
    ov_cnt = 0;
    for (int f = 0; f < 300; f++) begin
      int op;
      op = int'($urandom_range(0, 255));
      step(1, 11'(op));
      if (op_valid) ov_cnt++;
      step(0, 11'(3 * op));
      if (op_valid) ov_cnt++;
      step(0, 11'(7 * op));
      if (op_valid) ov_cnt++;
      step(0, 11'(8 * op));
      chk("sat_pulse", 32'({op_valid, err, op_out}), 32'({1'b1, 1'b0, 8'(op)}));
    end
    chk("sat_good_cnt", 32'(good_cnt), 32'd255);
    chk("sat_bad_cnt", 32'(bad_cnt), 32'd0);
    chk("sat_no_offphase_pulse", 32'(ov_cnt), 32'd0);

    // Reset in P2: outputs clear at once, and no err follows.
    step(1, 11'd7);
    step(0, 11'd21);
    chk("pre_reset_locked", 32'(locked), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'(pk(0,0,0,0,0,0,0)));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(0, 11'd56);
    chk("after_reset_1", 32'(outs()), 32'(pk(0,0,0,0,0,0,0)));
    step(0, 11'd0);
    chk("after_reset_2", 32'(outs()), 32'(pk(0,0,0,0,0,0,0)));
    step(1, 11'd4);
    chk("after_reset_grant", 32'(outs()), 32'(pk(0,0,0,1,0,0,0)));

    // Randomized stream compared cycle by cycle with the frame-level model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      if (plan.size() == 0) plan_frame();
      w = plan.pop_front();
      step(w.g, w.d);
      model_step(w.g, w.d);
      chk($sformatf("rand_cyc%0d", c), 32'(outs()),
          32'(pk(m_ov, m_err, m_code, m_lock, m_op, m_good, m_bad)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
